stream_arbiter: RTL and testbench

//  Packet-aware round-robin arbiter: shares one downstream valid/ready stream

---
 rtl/stream_arbiter_if.sv | 24 ++
 rtl/stream_arbiter.sv | 61 ++++++
 tb/tb_stream_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stream_arbiter_if.sv
// stream_arbiter_if: upstream and downstream valid/ready stream signals of the packet arbiter
interface stream_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int COUNT = 2
);
  localparam int IW = $clog2(COUNT);
  logic [COUNT-1:0] s_valid;
  logic [COUNT-1:0] s_ready;
  logic [COUNT-1:0] s_last;
  logic [COUNT-1:0][WIDTH-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  logic [IW-1:0] m_index;
  logic [WIDTH-1:0] m_data;
  modport master (
    input  s_valid, s_last, s_data, m_ready,
    output s_ready, m_valid, m_last, m_index, m_data
  );
  modport slave (
    output s_valid, s_last, s_data, m_ready,
    input  s_ready, m_valid, m_last, m_index, m_data
  );
endinterface

// File: rtl/stream_arbiter.sv
// stream_arbiter: packet-locked round-robin arbiter with a registered output stage
module stream_arbiter #(
  parameter int WIDTH = 32,
  parameter int COUNT = 2
) (
  input  logic clk,
  input  logic reset_n,
  stream_arbiter_if.master bus,
  output logic busy
);
  localparam int IW = $clog2(COUNT);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, grant, pick, idx;
  logic accept;
  assign accept = (state == LOCKED) && bus.s_valid[grant] && (!bus.m_valid || bus.m_ready);
  assign busy = (state == LOCKED);
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int i = COUNT; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % COUNT);
      pick = bus.s_valid[idx] ? idx : pick;
    end
  end
  always_comb begin
    state_n = state;
    bus.s_ready = '0;
    if (state == IDLE) begin
      state_n = |bus.s_valid ? LOCKED : IDLE;
    end else begin
      bus.s_ready[grant] = !bus.m_valid || bus.m_ready;
      state_n = (accept && bus.s_last[grant]) ? IDLE : LOCKED;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= IW'(COUNT - 1);
      grant <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last <= 1'b0;
      bus.m_index <= '0;
      bus.m_data <= '0;
    end else begin
      if (state == IDLE && |bus.s_valid) grant <= pick;
      if (accept) begin
        bus.m_valid <= 1'b1;
        bus.m_data <= bus.s_data[grant];
        bus.m_last <= bus.s_last[grant];
        bus.m_index <= grant;
        if (bus.s_last[grant]) ptr <= grant;
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed vector table plus stall, gap and wrap sequences for stream_arbiter
module tb_stream_arbiter;
  logic clk = 1'b0;
  logic rn, rn4, busy, busy4;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  stream_arbiter_if #(.WIDTH(32), .COUNT(2)) ifc ();
  stream_arbiter_if #(.WIDTH(32), .COUNT(4)) ifc4 ();
  stream_arbiter #(.WIDTH(32), .COUNT(2)) dut (.clk(clk), .reset_n(rn), .bus(ifc), .busy(busy));
  stream_arbiter #(.WIDTH(32), .COUNT(4)) dut4 (.clk(clk), .reset_n(rn4), .bus(ifc4), .busy(busy4));
  typedef struct {
    logic rn;
    logic [1:0] sv, sl;
    logic [31:0] d0, d1;
    logic cr;
    logic [1:0] rdy;
    logic mv, ml, mi;
    logic [31:0] md;
    logic bz;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] gd[$], ed[$];
  int gl[$], el[$], gi[$], ei[$];
  function automatic vec_t mk(int r, int sv, int sl, int d0, int d1, int cr, int rdy, int mv, int ml, int mi, int md, int bz);
    vec_t v;
    v.rn = 1'(r); v.sv = 2'(sv); v.sl = 2'(sl); v.d0 = 32'(d0); v.d1 = 32'(d1); v.cr = 1'(cr);
    v.rdy = 2'(rdy); v.mv = 1'(mv); v.ml = 1'(ml); v.mi = 1'(mi); v.md = 32'(md); v.bz = 1'(bz);
    return v;
  endfunction
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic cmp_out(string nm);
    chk({nm, "_count"}, 32'(gd.size()), 32'(ed.size()));
    for (int k = 0; k < ed.size(); k++) begin
      if (k < gd.size()) begin
        chk({nm, "_data"}, gd[k], ed[k]);
        chk({nm, "_last"}, 32'(gl[k]), 32'(el[k]));
        chk({nm, "_index"}, 32'(gi[k]), 32'(ei[k]));
      end
    end
  endtask
  task automatic clr();
    gd.delete(); gl.delete(); gi.delete(); ed.delete(); el.delete(); ei.delete();
  endtask
  task automatic grab();
    if (ifc.m_valid && ifc.m_ready) begin
      gd.push_back(ifc.m_data); gl.push_back(int'(ifc.m_last)); gi.push_back(int'(ifc.m_index));
    end
  endtask
  task automatic expect_beat(int d, int l, int i);
    ed.push_back(32'(d)); el.push_back(l); ei.push_back(i);
  endtask
  initial begin
    int b, b0, b1, gap;
    logic drop, done0;
    rn = 1'b0; rn4 = 1'b0;
    ifc.s_valid = '0; ifc.s_last = '0; ifc.s_data = '0; ifc.m_ready = 1'b1;
    ifc4.s_valid = '0; ifc4.s_last = '0; ifc4.s_data = '0; ifc4.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    tbl.push_back(mk(0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 'h100, 'h200, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 'h100, 'h200, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3, 0, 'h101, 'h200, 1, 1, 1, 0, 0, 'h100, 1));
    tbl.push_back(mk(1, 3, 0, 'h102, 'h200, 1, 1, 1, 0, 0, 'h101, 1));
    tbl.push_back(mk(1, 3, 1, 'h103, 'h200, 1, 1, 1, 0, 0, 'h102, 1));
    tbl.push_back(mk(1, 3, 0, 'h104, 'h200, 1, 0, 1, 1, 0, 'h103, 0));
    tbl.push_back(mk(1, 3, 0, 'h104, 'h200, 1, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3, 0, 'h104, 'h201, 1, 2, 1, 0, 1, 'h200, 1));
    tbl.push_back(mk(1, 3, 0, 'h104, 'h202, 1, 2, 1, 0, 1, 'h201, 1));
    tbl.push_back(mk(1, 3, 2, 'h104, 'h203, 1, 2, 1, 0, 1, 'h202, 1));
    tbl.push_back(mk(1, 3, 0, 'h104, 'h204, 1, 0, 1, 1, 1, 'h203, 0));
    tbl.push_back(mk(1, 3, 0, 'h104, 'h204, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3, 0, 'h105, 'h204, 1, 1, 1, 0, 0, 'h104, 1));
    tbl.push_back(mk(1, 3, 0, 'h106, 'h204, 1, 1, 1, 0, 0, 'h105, 1));
    tbl.push_back(mk(1, 3, 1, 'h107, 'h204, 1, 1, 1, 0, 0, 'h106, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 'h107, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 'h300, 'h210, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 'h300, 'h210, 1, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3, 0, 'h300, 'h211, 1, 2, 1, 0, 1, 'h210, 1));
    tbl.push_back(mk(0, 3, 0, 'h300, 'h212, 0, 0, 1, 0, 1, 'h211, 1));
    tbl.push_back(mk(1, 3, 1, 'h300, 'h212, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 1, 'h300, 'h212, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 'h300, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      rn = tbl[i].rn; ifc.s_valid = tbl[i].sv; ifc.s_last = tbl[i].sl;
      ifc.s_data[0] = tbl[i].d0; ifc.s_data[1] = tbl[i].d1; ifc.m_ready = 1'b1;
      #1;
      if (tbl[i].cr) chk($sformatf("row%0d_s_ready", i), 32'(ifc.s_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_m_valid", i), 32'(ifc.m_valid), 32'(tbl[i].mv));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      if (tbl[i].mv) begin
        chk($sformatf("row%0d_m_data", i), ifc.m_data, tbl[i].md);
        chk($sformatf("row%0d_m_last", i), 32'(ifc.m_last), 32'(tbl[i].ml));
        chk($sformatf("row%0d_m_index", i), 32'(ifc.m_index), 32'(tbl[i].mi));
      end
    end
    clr();
    b = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ifc.s_valid = {1'b0, b < 4}; ifc.s_last = {1'b0, b == 3};
      ifc.s_data[0] = 32'h400 + 32'(b); ifc.m_ready = !(c >= 4 && c < 9);
      #1;
      if (!ifc.m_ready) begin
        chk("stall_m_valid", 32'(ifc.m_valid), 32'd1);
        chk("stall_m_data", ifc.m_data, 32'h402);
        chk("stall_s_ready", 32'(ifc.s_ready), 32'd0);
        chk("stall_in_flight", 32'(b - gd.size()), 32'd1);
      end
      if (ifc.s_valid[0] && ifc.s_ready[0]) b++;
      grab();
    end
    for (int k = 0; k < 4; k++) expect_beat('h400 + k, int'(k == 3), 0);
    cmp_out("stall");
    clr();
    b0 = 0; b1 = 0; gap = 0; done0 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      drop = (b0 == 2 && gap < 3);
      if (drop) gap++;
      ifc.s_valid = {c >= 1 && b1 < 2, b0 < 4 && !drop};
      ifc.s_last = {b1 == 1, b0 == 3};
      ifc.s_data[0] = 32'h500 + 32'(b0); ifc.s_data[1] = 32'h600 + 32'(b1); ifc.m_ready = 1'b1;
      #1;
      if (!done0) chk("gap_src1_blocked", 32'(ifc.s_ready[1]), 32'd0);
      if (drop) chk("gap_busy", 32'(busy), 32'd1);
      if (ifc.s_valid[0] && ifc.s_ready[0]) begin
        if (ifc.s_last[0]) done0 = 1'b1;
        b0++;
      end
      if (ifc.s_valid[1] && ifc.s_ready[1]) b1++;
      grab();
    end
    for (int k = 0; k < 4; k++) expect_beat('h500 + k, int'(k == 3), 0);
    expect_beat('h600, 0, 1);
    expect_beat('h601, 1, 1);
    cmp_out("gap");
    clr();
    @(negedge clk);
    rn4 = 1'b1;
    b = 0;
    for (int c = 0; c < 15; c++) begin
      ifc4.s_valid = {1'b0, b < 2, 2'b00}; ifc4.s_last = 4'b0100;
      ifc4.s_data[2] = 32'hA + 32'(b); ifc4.m_ready = 1'b1;
      #1;
      if (ifc4.s_valid[2] && ifc4.s_ready[2]) b++;
      if (ifc4.m_valid && ifc4.m_ready) begin
        gd.push_back(ifc4.m_data); gl.push_back(int'(ifc4.m_last)); gi.push_back(int'(ifc4.m_index));
      end
      @(negedge clk);
    end
    expect_beat('hA, 1, 2);
    expect_beat('hB, 1, 2);
    cmp_out("wrap4");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
